// File: rtl/debug_dump_pkg.sv
// ============================================================================
// Module      : debug_dump_pkg
// Description : Shared state encoding, ASCII constants and nibble-to-ASCII
//               helper for the debug dump UART block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_dump_pkg;

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_wait = 3'd1;
   localparam logic [2:0] c_st_load = 3'd2;
   localparam logic [2:0] c_st_send = 3'd3;
   localparam logic [2:0] c_st_next = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = c_st_idle,
      ST_WAIT = c_st_wait,
      ST_LOAD = c_st_load,
      ST_SEND = c_st_send,
      ST_NEXT = c_st_next
   } state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_8n1.sv
// ============================================================================
// Module      : uart_tx_8n1
// Description : 8N1 UART transmitter with valid/ready load; a new frame may be
//               loaded in the final stop-bit cycle for gapless streaming.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_8n1 #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_frame_end,
   output logic       o_frame_ending
);

   localparam int c_baud_w = $clog2(CLKS_PER_BIT);
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
   localparam logic [c_baud_w-1:0] c_baud_prev = c_baud_w'(CLKS_PER_BIT - 2);

   logic                r_active;
   logic [c_baud_w-1:0] r_baud;
   logic [3:0]          r_bit;
   logic [8:0]          r_shift;
   logic                r_tx;
   logic                w_stop;
   logic                w_frame_end;
   logic                w_load;

   assign w_stop         = (r_bit == 4'd9);
   assign w_frame_end    = r_active && w_stop && (r_baud == c_baud_last);
   assign w_load         = i_valid && o_ready;
   assign o_ready        = !r_active || w_frame_end;
   assign o_tx           = r_tx;
   assign o_frame_end    = w_frame_end;
   // One cycle of warning lets the caller overlap its own bookkeeping with the stop bit.
   assign o_frame_ending = r_active && w_stop && (r_baud == c_baud_prev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_baud   <= '0;
         r_bit    <= 4'd0;
         r_shift  <= '1;
         r_tx     <= 1'b1;
      end else if (w_load) begin
         r_active <= 1'b1;
         r_baud   <= '0;
         r_bit    <= 4'd0;
         r_shift  <= {1'b1, i_data};
         r_tx     <= 1'b0;
      end else if (r_active) begin
         if (r_baud == c_baud_last) begin
            r_baud <= '0;
            if (w_stop) begin
               r_active <= 1'b0;
               r_bit    <= 4'd0;
            end else begin
               r_bit   <= r_bit + 4'd1;
               r_tx    <= r_shift[0];
               r_shift <= {1'b1, r_shift[8:1]};
            end
         end else begin
            r_baud <= r_baud + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/debug_dump_uart.sv
// ============================================================================
// Module      : debug_dump_uart
// Description : Walks the RAM debug port and streams every byte over UART 8N1.
//               Define DEBUG_DUMP_HEX_EN for ASCII hex output with CR/LF tail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_dump_uart
   import debug_dump_pkg::*;
#(
   parameter int DEBUG_LEN_BITS = 3,
   parameter int CLKS_PER_BIT   = 16
) (
   input  logic                      debug_clk,
   input  logic                      debug_rst,
   input  logic                      start,
   output logic [DEBUG_LEN_BITS-1:0] addr_out,
   input  logic [7:0]                byte_in,
   output logic                      uart_tx,
   output logic                      busy,
   output logic                      done
);

   state_t                    r_state;
   logic [DEBUG_LEN_BITS-1:0] r_addr;
   logic                      r_busy;
   logic                      r_done;
   logic                      w_last_addr;
   logic                      w_pending;
   logic                      w_tx_valid;
   logic                      w_tx_ready;
   logic                      w_frame_end;
   logic                      w_frame_ending;
   logic [7:0]                w_tx_data;

   assign w_last_addr = (r_addr == {DEBUG_LEN_BITS{1'b1}});

`ifdef DEBUG_DUMP_HEX_EN
   logic [3:0] r_low_nibble;
   logic [1:0] r_char_idx;

   // Character index: 0 high nibble, 1 low nibble, 2 CR, 3 LF (last byte only).
   assign w_pending = (r_char_idx == 2'd0) || (w_last_addr && (r_char_idx != 2'd3));

   always_comb begin
      w_tx_data = nibble_to_ascii(byte_in[7:4]);
      if (r_state == ST_SEND) begin
         case (r_char_idx)
            2'd0:    w_tx_data = nibble_to_ascii(r_low_nibble);
            2'd1:    w_tx_data = ASCII_CR;
            default: w_tx_data = ASCII_LF;
         endcase
      end
   end
`else
   assign w_pending = 1'b0;
   assign w_tx_data = byte_in;
`endif

   assign w_tx_valid = (r_state == ST_LOAD) || ((r_state == ST_SEND) && w_pending);
   assign addr_out   = r_addr;
   assign busy       = r_busy;
   assign done       = r_done;

   uart_tx_8n1 #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk            (debug_clk),
      .rst            (debug_rst),
      .i_valid        (w_tx_valid),
      .i_data         (w_tx_data),
      .o_ready        (w_tx_ready),
      .o_tx           (uart_tx),
      .o_frame_end    (w_frame_end),
      .o_frame_ending (w_frame_ending)
   );

   // NEXT overlaps the last stop-bit cycle, so only NEXT/WAIT-length idle remains between bytes.
   always_ff @(posedge debug_clk or posedge debug_rst) begin
      if (debug_rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef DEBUG_DUMP_HEX_EN
         r_low_nibble <= 4'd0;
         r_char_idx   <= 2'd0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: r_state <= ST_LOAD;
            ST_LOAD: begin
               if (w_tx_ready) begin
`ifdef DEBUG_DUMP_HEX_EN
                  r_low_nibble <= byte_in[3:0];
                  r_char_idx   <= 2'd0;
`endif
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_pending) begin
`ifdef DEBUG_DUMP_HEX_EN
                  if (w_tx_ready) r_char_idx <= r_char_idx + 2'd1;
`endif
               end else if (!w_last_addr) begin
                  if (w_frame_ending) r_state <= ST_NEXT;
               end else if (w_frame_end) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_NEXT: begin
               r_addr  <= r_addr + 1'b1;
               r_state <= ST_WAIT;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_debug_dump_uart.sv
// ============================================================================
// Module      : tb_debug_dump_uart
// Description : Directed self-checking bench for debug_dump_uart (raw build by
//               default, hex build when DEBUG_DUMP_HEX_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_debug_dump_uart;

   localparam int c_cpb = 4;
`ifdef DEBUG_DUMP_HEX_EN
   localparam int c_byte_period = 20*c_cpb + 2;
   localparam int c_last_frames = 4;
`else
   localparam int c_byte_period = 10*c_cpb + 2;
   localparam int c_last_frames = 1;
`endif
   localparam int c_dump_cycles = 2 + 7*c_byte_period + c_last_frames*10*c_cpb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] addr_out;
   logic [7:0] byte_in;
   logic       uart_tx;
   logic       busy;
   logic       done;
   logic [7:0] mem [8];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   debug_dump_uart #(
      .DEBUG_LEN_BITS (3),
      .CLKS_PER_BIT   (c_cpb)
   ) dut (
      .debug_clk (clk),
      .debug_rst (rst),
      .start     (start),
      .addr_out  (addr_out),
      .byte_in   (byte_in),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) byte_in <= mem[addr_out];

   task automatic load_mem(input logic [7:0] b0, input logic [7:0] step);
      for (int i = 0; i < 8; i++) mem[i] = b0 + step * 8'(i);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start(output int e0);
      @(negedge clk);
      start = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int d, output bit ok);
      ok = 1'b0;
      d  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            d  = cyc;
            break;
         end
      end
   endtask

   task automatic uart_rx(input int budget, output logic [7:0] b, output int s, output bit ok);
      int off;
      ok  = 1'b0;
      b   = 8'h00;
      s   = 0;
      off = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            ok = 1'b1;
            s  = cyc;
            break;
         end
      end
      if (ok) begin
         for (int k = 0; k < 8; k++) begin
            repeat (c_cpb*(k+1) + c_cpb/2 - off) @(negedge clk);
            off  = c_cpb*(k+1) + c_cpb/2;
            b[k] = uart_tx;
         end
         repeat (9*c_cpb + c_cpb/2 - off) @(negedge clk);
         if (uart_tx !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (addr_out !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr_out); end
      rst = 1'b0;
   endtask

   task automatic test_latency();
      int e0;
      int low;
      load_mem(8'h01, 8'h00);
      pulse_start(e0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy_e0: got %b expected 1", busy); end
      n_checks++; if (addr_out !== 3'd0) begin n_fail++; $display("FAIL lat_addr_e0: got %0d expected 0", addr_out); end
      n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL lat_tx_e0: got %b expected 1", uart_tx); end
      @(negedge clk);
      n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL lat_tx_e1: got %b expected 1", uart_tx); end
      @(negedge clk);
      n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL lat_tx_e2: got %b expected 0", uart_tx); end
      low = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (uart_tx === 1'b0) low++;
         else break;
      end
      n_checks++; if (low !== c_cpb) begin n_fail++; $display("FAIL lat_start_len: got %0d expected %0d", low, c_cpb); end
      do_reset();
   endtask

`ifdef DEBUG_DUMP_HEX_EN
   task automatic test_hex_dump();
      logic [7:0] exp_c [18];
      logic [7:0] b;
      int e0, s, d, exp_s;
      bit ok;
      load_mem(8'h00, 8'h00);
      mem[0] = 8'hA5;
      exp_c[0] = 8'h41;
      exp_c[1] = 8'h35;
      for (int i = 2; i < 16; i++) exp_c[i] = 8'h30;
      exp_c[16] = 8'h0D;
      exp_c[17] = 8'h0A;
      pulse_start(e0);
      for (int k = 0; k < 18; k++) begin
         uart_rx(200, b, s, ok);
         exp_s = (k < 16) ? e0 + 2 + (k/2)*c_byte_period + (k%2)*10*c_cpb
                          : e0 + 2 + 7*c_byte_period + (k-14)*10*c_cpb;
         n_checks++; if (!ok || b !== exp_c[k]) begin n_fail++; $display("FAIL hex_char%0d: got %02h ok=%0d expected %02h", k, b, ok, exp_c[k]); end
         n_checks++; if (s !== exp_s) begin n_fail++; $display("FAIL hex_start%0d: got cycle %0d expected %0d", k, s - e0, exp_s - e0); end
      end
      wait_done(20, d, ok);
      n_checks++; if (!ok || d !== e0 + c_dump_cycles) begin n_fail++; $display("FAIL hex_done: got cycle %0d ok=%0d expected %0d", d - e0, ok, c_dump_cycles); end
      do_reset();
   endtask
`else
   task automatic test_raw_dump();
      logic [7:0] b;
      int e0, s, d, extra;
      bit ok;
      load_mem(8'h11, 8'h11);
      pulse_start(e0);
      for (int k = 0; k < 8; k++) begin
         uart_rx(100, b, s, ok);
         n_checks++; if (!ok || b !== mem[k]) begin n_fail++; $display("FAIL raw_byte%0d: got %02h ok=%0d expected %02h", k, b, ok, mem[k]); end
         n_checks++; if (s !== e0 + 2 + k*c_byte_period) begin n_fail++; $display("FAIL raw_start%0d: got cycle %0d expected %0d", k, s - e0, 2 + k*c_byte_period); end
      end
      wait_done(20, d, ok);
      n_checks++; if (!ok || d !== e0 + 8*42) begin n_fail++; $display("FAIL raw_done_time: got cycle %0d ok=%0d expected %0d", d - e0, ok, 8*42); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL raw_busy_at_done: got %b expected 0", busy); end
      extra = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL raw_done_once: got %0d extra pulses expected 0", extra); end
      do_reset();
   endtask
`endif

   task automatic test_start_ignored();
      int e0, dones, busy_low, done_at;
      bit over;
      load_mem(8'h10, 8'h03);
      pulse_start(e0);
      dones    = 0;
      busy_low = 0;
      done_at  = 0;
      over     = 1'b0;
      for (int i = 1; i < c_dump_cycles + 80; i++) begin
         start = (i == 30 || i == 120 || i == 250);
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            done_at = cyc;
            over    = 1'b1;
         end else if (!over && busy !== 1'b1) begin
            busy_low++;
         end
      end
      start = 1'b0;
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
      n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL ign_busy_drop: got %0d low cycles expected 0", busy_low); end
      n_checks++; if (done_at !== e0 + c_dump_cycles) begin n_fail++; $display("FAIL ign_done_time: got cycle %0d expected %0d", done_at - e0, c_dump_cycles); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_requeue: got busy %b expected 0", busy); end
      do_reset();
   endtask

   task automatic test_async_reset();
      logic [7:0] b, exp_b;
      int e0, e1, s;
      bit ok;
      load_mem(8'h11, 8'h11);
`ifdef DEBUG_DUMP_HEX_EN
      exp_b = 8'h31;
`else
      exp_b = 8'h11;
`endif
      pulse_start(e0);
      repeat (2 + 3*c_byte_period + c_cpb + 1) @(negedge clk);
      n_checks++; if (addr_out !== 3'd3) begin n_fail++; $display("FAIL arst_pre_addr: got %0d expected 3", addr_out); end
      n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL arst_pre_tx: got %b expected 0", uart_tx); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL arst_tx: got %b expected 1", uart_tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
      n_checks++; if (addr_out !== 3'd0) begin n_fail++; $display("FAIL arst_addr: got %0d expected 0", addr_out); end
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      pulse_start(e1);
      n_checks++; if (addr_out !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_restart: got addr %0d busy %b expected addr 0 busy 1", addr_out, busy); end
      uart_rx(20, b, s, ok);
      n_checks++; if (!ok || b !== exp_b || s !== e1 + 2) begin n_fail++; $display("FAIL arst_first_byte: got %02h at %0d ok=%0d expected %02h at 2", b, s - e1, ok, exp_b); end
      do_reset();
   endtask

   task automatic test_back_to_back();
      int e0, d;
      bit ok;
      load_mem(8'h5A, 8'h01);
      @(negedge clk);
      start = 1'b1;
      e0 = cyc + 1;
      for (int rep = 0; rep < 2; rep++) begin
         wait_done(c_dump_cycles + 20, d, ok);
         n_checks++; if (!ok || d !== e0 + c_dump_cycles) begin n_fail++; $display("FAIL b2b_done%0d: got cycle %0d ok=%0d expected %0d", rep, d - e0, ok, c_dump_cycles); end
         @(negedge clk);
         n_checks++; if (busy !== 1'b1 || uart_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d: got busy %b tx %b expected busy 1 tx 1", rep, busy, uart_tx); end
         @(negedge clk);
         n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_gap%0d: got tx %b expected 1", rep, uart_tx); end
         @(negedge clk);
         n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL b2b_startbit%0d: got tx %b expected 0", rep, uart_tx); end
         e0 = d + 1;
      end
      start = 1'b0;
      wait_done(c_dump_cycles + 20, d, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_final_done: got timeout expected done"); end
      do_reset();
   endtask

   initial begin
      load_mem(8'h00, 8'h00);
      test_reset();
      test_latency();
`ifdef DEBUG_DUMP_HEX_EN
      test_hex_dump();
`else
      test_raw_dump();
`endif
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
